// File: rtl/ff_lockstep_checker.sv
// Lockstep checker comparing three D-flop equivalents (SR/JK/T based) against a registered model of d.
// Optional first-mismatch capture is built when FIRST_MISMATCH_CAPTURE_EN is defined.
module ff_lockstep_checker #(
  parameter int WARMUP    = 2,
  parameter int ERR_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic        d,
  input  logic        q_sr,
  input  logic        q_jk,
  input  logic        q_t,
  output logic [1:0]  state,
  output logic [2:0]  mis_vec,
  output logic        agree,
  output logic        err_sticky,
  output logic [7:0]  mismatch_cnt,
  output logic        cap_valid,
  output logic [2:0]  cap_vec,
  output logic [15:0] cap_cycle
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARM   = 2'b01,
    S_CHECK = 2'b10,
    S_FAIL  = 2'b11
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_exp;
  logic [3:0]  r_arm_cnt;
  logic [15:0] r_cyc;
  logic [2:0]  r_mis_vec;
  logic        r_agree;
  logic        r_err_sticky;
  logic [7:0]  r_mismatch_cnt;

  logic [2:0]  w_mis;
  logic        w_any;
  logic [8:0]  w_cnt_plus;
  logic [7:0]  w_cnt_sat;
  logic        w_limit_hit;
  logic        w_compare;

  assign w_mis       = {q_sr ^ r_exp, q_jk ^ r_exp, q_t ^ r_exp};
  assign w_any       = |w_mis;
  assign w_cnt_plus  = {1'b0, r_mismatch_cnt} + 9'd1;
  assign w_cnt_sat   = w_cnt_plus[8] ? 8'hFF : w_cnt_plus[7:0];
  assign w_limit_hit = w_any && (w_cnt_plus == 9'(ERR_LIMIT));
  // A compare only counts when neither clr nor en=0 pre-empts it.
  assign w_compare   = (r_state == S_CHECK) && en && !clr;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (clr) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (en) w_state_next = S_ARM;
        S_ARM: begin
          if (!en)                  w_state_next = S_IDLE;
          else if (r_arm_cnt == 4'd0) w_state_next = S_CHECK;
        end
        S_CHECK: begin
          if (!en)              w_state_next = S_IDLE;
          else if (w_limit_hit) w_state_next = S_FAIL;
        end
        default: w_state_next = S_FAIL;
      endcase
    end
  end

  // Output logic
  always_comb begin
    state        = r_state;
    mis_vec      = r_mis_vec;
    agree        = r_agree;
    err_sticky   = r_err_sticky;
    mismatch_cnt = r_mismatch_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_exp          <= 1'b0;
      r_arm_cnt      <= 4'd0;
      r_cyc          <= 16'd0;
      r_mis_vec      <= 3'b000;
      r_agree        <= 1'b1;
      r_err_sticky   <= 1'b0;
      r_mismatch_cnt <= 8'd0;
    end else begin
      r_exp <= d;
      if (clr) begin
        r_arm_cnt      <= 4'd0;
        r_cyc          <= 16'd0;
        r_mis_vec      <= 3'b000;
        r_agree        <= 1'b1;
        r_err_sticky   <= 1'b0;
        r_mismatch_cnt <= 8'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_mis_vec <= 3'b000;
            r_agree   <= 1'b1;
            if (en) r_arm_cnt <= 4'(WARMUP - 1);
          end
          S_ARM: begin
            r_mis_vec <= 3'b000;
            r_agree   <= 1'b1;
            if (en) begin
              if (r_arm_cnt == 4'd0) r_cyc <= 16'd0;
              else                   r_arm_cnt <= r_arm_cnt - 4'd1;
            end
          end
          S_CHECK: begin
            if (!en) begin
              r_mis_vec <= 3'b000;
              r_agree   <= 1'b1;
            end else begin
              r_mis_vec <= w_mis;
              r_agree   <= ~w_any;
              r_cyc     <= r_cyc + 16'd1;
              if (w_any) begin
                r_mismatch_cnt <= w_cnt_sat;
                r_err_sticky   <= 1'b1;
              end
            end
          end
          default: begin
            // FAIL freezes everything until reset or clr.
          end
        endcase
      end
    end
  end

`ifdef FIRST_MISMATCH_CAPTURE_EN
  logic        r_cap_valid;
  logic [2:0]  r_cap_vec;
  logic [15:0] r_cap_cycle;

  always_ff @(posedge clk) begin
    if (reset || (!reset && clr)) begin
      r_cap_valid <= 1'b0;
      r_cap_vec   <= 3'b000;
      r_cap_cycle <= 16'd0;
    end else if (w_compare && w_any && !r_cap_valid) begin
      r_cap_valid <= 1'b1;
      r_cap_vec   <= w_mis;
      r_cap_cycle <= r_cyc;
    end
  end

  assign cap_valid = r_cap_valid;
  assign cap_vec   = r_cap_vec;
  assign cap_cycle = r_cap_cycle;
`else
  logic w_unused_compare;
  assign w_unused_compare = w_compare;
  assign cap_valid = 1'b0;
  assign cap_vec   = 3'b000;
  assign cap_cycle = 16'd0;
`endif

endmodule
